// File: rtl/iter_divider_pkg.sv
// Shared types and width defaults for the iterative divider.
package iter_divider_pkg;

    // Default operand width, quotient bits per cycle and tag width.
    localparam int unsigned DIV_WIDTH_DEF = 32;
    localparam int unsigned DIV_BPC_DEF   = 1;
    localparam int unsigned DIV_TAG_W_DEF = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Per-operation flags latched at accept time.
    typedef struct packed {
        logic use_mod;
        logic neg_q;
        logic neg_r;
    } op_flags_t;

endpackage

// File: rtl/iter_divider_div_step.sv
// One restoring division step: shifted partial remainder in, quotient bit and new remainder out.
module iter_divider_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   part_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic             q_bit_o,
    output logic [WIDTH-1:0] rem_o
);

    logic [WIDTH:0] diff_c;

    // Trial subtract; the remainder invariant keeps the borrow in the top bit.
    always_comb begin
        diff_c  = part_i - {1'b0, dvs_i};
        q_bit_o = ~diff_c[WIDTH];
        rem_o   = q_bit_o ? diff_c[WIDTH-1:0] : part_i[WIDTH-1:0];
    end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle restoring divider with signed/unsigned, quotient/remainder select and flush.
module iter_divider
    import iter_divider_pkg::*;
#(
    parameter int unsigned WIDTH          = DIV_WIDTH_DEF,
    parameter int unsigned BITS_PER_CYCLE = DIV_BPC_DEF,
    parameter int unsigned TAG_W          = DIV_TAG_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic             in_use_mod,
    input  logic [WIDTH-1:0] in_src1,
    input  logic [WIDTH-1:0] in_src2,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int unsigned N     = WIDTH / BITS_PER_CYCLE;
    localparam int unsigned CNT_W = $clog2(N + 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    op_flags_t        flags_q, flags_d;

    logic             accept;
    logic [WIDTH-1:0] mag1, mag2;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    logic [WIDTH-1:0] rem_chain [BITS_PER_CYCLE+1];
    logic [WIDTH-1:0] quo_chain [BITS_PER_CYCLE+1];

    assign in_ready  = ~flush & ((state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready));
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign out_tag   = tag_q;

    // Chain of restoring steps retiring BITS_PER_CYCLE quotient bits per edge.
    assign rem_chain[0] = rem_q;
    assign quo_chain[0] = quo_q;
    for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_step
        logic q_bit;
        iter_divider_div_step #(.WIDTH(WIDTH)) u_step (
            .part_i  ({rem_chain[k], quo_chain[k][WIDTH-1]}),
            .dvs_i   (dvs_q),
            .q_bit_o (q_bit),
            .rem_o   (rem_chain[k+1])
        );
        assign quo_chain[k+1] = {quo_chain[k][WIDTH-2:0], q_bit};
    end

    // Operand magnitudes for signed mode.
    always_comb begin
        mag1 = (in_signed && in_src1[WIDTH-1]) ? (~in_src1 + WIDTH'(1)) : in_src1;
        mag2 = (in_signed && in_src2[WIDTH-1]) ? (~in_src2 + WIDTH'(1)) : in_src2;
    end

    // Sign fix-up and result select, driven only from registered state.
    always_comb begin
        quo_fix    = flags_q.neg_q ? (~quo_q + WIDTH'(1)) : quo_q;
        rem_fix    = flags_q.neg_r ? (~rem_q + WIDTH'(1)) : rem_q;
        out_result = '0;
        if (state_q == ST_DONE) begin
            out_result = flags_q.use_mod ? rem_fix : quo_fix;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        tag_d   = tag_q;
        flags_d = flags_q;

        case (state_q)
            ST_BUSY: begin
                rem_d = rem_chain[BITS_PER_CYCLE];
                quo_d = quo_chain[BITS_PER_CYCLE];
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: ;
        endcase

        if (accept) begin
            tag_d           = in_tag;
            flags_d.use_mod = in_use_mod;
            if (in_src2 == '0) begin
                // Divide by zero bypasses iteration; results are raw.
                quo_d         = '1;
                rem_d         = in_src1;
                dvs_d         = '0;
                cnt_d         = '0;
                flags_d.neg_q = 1'b0;
                flags_d.neg_r = 1'b0;
                state_d       = ST_DONE;
            end else begin
                quo_d         = mag1;
                rem_d         = '0;
                dvs_d         = mag2;
                cnt_d         = CNT_W'(N);
                flags_d.neg_q = in_signed & (in_src1[WIDTH-1] ^ in_src2[WIDTH-1]);
                flags_d.neg_r = in_signed & in_src1[WIDTH-1];
                state_d       = ST_BUSY;
            end
        end

        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            tag_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            tag_q   <= tag_d;
            flags_q <= flags_d;
        end
    end

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider: one 1-bit/cycle and one 2-bit/cycle instance.
module tb_iter_divider;

    localparam int W  = 32;
    localparam int TW = 5;

    logic          clk;
    logic          reset, flush, out_ready, in_signed, in_use_mod;
    logic [W-1:0]  src1, src2;
    logic [TW-1:0] tag;
    logic          valid_a, valid_b;
    logic          ready_a, ready_b, ov_a, ov_b, busy_a, busy_b;
    logic [W-1:0]  res_a, res_b;
    logic [TW-1:0] otag_a, otag_b;

    int n_tests = 0;
    int n_fail  = 0;

    iter_divider #(.WIDTH(W), .BITS_PER_CYCLE(1), .TAG_W(TW)) dut_a (
        .clk(clk), .reset(reset), .in_valid(valid_a), .in_ready(ready_a),
        .in_signed(in_signed), .in_use_mod(in_use_mod), .in_src1(src1), .in_src2(src2),
        .in_tag(tag), .flush(flush), .out_valid(ov_a), .out_ready(out_ready),
        .out_result(res_a), .out_tag(otag_a), .busy(busy_a)
    );

    iter_divider #(.WIDTH(W), .BITS_PER_CYCLE(2), .TAG_W(TW)) dut_b (
        .clk(clk), .reset(reset), .in_valid(valid_b), .in_ready(ready_b),
        .in_signed(in_signed), .in_use_mod(in_use_mod), .in_src1(src1), .in_src2(src2),
        .in_tag(tag), .flush(flush), .out_valid(ov_b), .out_ready(out_ready),
        .out_result(res_b), .out_tag(otag_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference division straight from the arithmetic definition.
    function automatic logic [W-1:0] ref_div(input logic sgn, input logic md,
                                             input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] q, r;
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = a;
                r = '0;
            end else begin
                q = 32'($signed(a) / $signed(b));
                r = 32'($signed(a) % $signed(b));
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return md ? r : q;
    endfunction

    function automatic int exp_lat(input logic sel, input logic [W-1:0] b);
        if (b == 0) return 1;
        return sel ? (W / 2 + 1) : (W + 1);
    endfunction

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation, wait for out_valid; latency counts the accepting edge as 1.
    task automatic run_op(input logic sel, input logic sgn, input logic md,
                          input logic [W-1:0] a, input logic [W-1:0] b, input logic [TW-1:0] t,
                          output logic [W-1:0] res, output logic [TW-1:0] otag, output int lat);
        in_signed  = sgn;
        in_use_mod = md;
        src1       = a;
        src2       = b;
        tag        = t;
        if (sel) valid_b = 1'b1; else valid_a = 1'b1;
        #1;
        for (int i = 0; i < 50 && !(sel ? ready_b : ready_a); i++) step();
        step();
        valid_a = 1'b0;
        valid_b = 1'b0;
        lat = 1;
        while (!(sel ? ov_b : ov_a) && lat < 100) begin
            step();
            lat++;
        end
        res  = sel ? res_b : res_a;
        otag = sel ? otag_b : otag_a;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic check_op(input string name, input logic sel, input logic sgn, input logic md,
                            input logic [W-1:0] a, input logic [W-1:0] b, input logic [TW-1:0] t);
        logic [W-1:0]  res;
        logic [TW-1:0] otag;
        int            lat;
        run_op(sel, sgn, md, a, b, t, res, otag, lat);
        check({name, ".res"}, res, ref_div(sgn, md, a, b));
        check({name, ".tag"}, W'(otag), W'(t));
        check({name, ".lat"}, W'(lat), W'(exp_lat(sel, b)));
        consume();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0]  res, a, b;
        logic [TW-1:0] otag, t;
        logic          sgn, md, sel, seen;
        int            lat;

        reset = 1'b1; flush = 1'b0; out_ready = 1'b0; in_signed = 1'b0; in_use_mod = 1'b0;
        src1 = '0; src2 = '0; tag = '0; valid_a = 1'b0; valid_b = 1'b0;
        step();
        step();
        reset = 1'b0;
        #1;

        // Reset state
        check("rst.out_valid", W'(ov_a), 0);
        check("rst.busy", W'(busy_a), 0);
        check("rst.out_result", res_a, 0);
        check("rst.out_tag", W'(otag_a), 0);
        check("rst.in_ready", W'(ready_a), 1);
        check("rst.busy_b", W'(busy_b), 0);

        // Unsigned 100/7, quotient and remainder
        check_op("u100_7.q", 0, 0, 0, 100, 7, 3);
        check_op("u100_7.r", 0, 0, 1, 100, 7, 3);
        check("u100_7.const", ref_div(0, 0, 100, 7), 14);

        // Signed cases and overflow
        check_op("s-7_2.q", 0, 1, 0, 32'hFFFF_FFF9, 2, 1);
        check_op("s-7_2.r", 0, 1, 1, 32'hFFFF_FFF9, 2, 2);
        check_op("ovf.q", 0, 1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 4);
        check_op("ovf.r", 0, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 5);

        // Divide by zero, both modes
        check_op("dz.s.q", 0, 1, 0, 5, 0, 6);
        check_op("dz.u.q", 0, 0, 0, 5, 0, 7);
        check_op("dz.s.r", 0, 1, 1, 5, 0, 8);
        check_op("dz.u.r", 0, 0, 1, 5, 0, 9);

        // Flush during BUSY
        in_signed = 1'b0; in_use_mod = 1'b0; src1 = 1000; src2 = 10; tag = 10;
        valid_a = 1'b1;
        step();
        valid_a = 1'b0;
        repeat (9) step();
        flush = 1'b1;
        #1;
        check("flush.ready_blocked", W'(ready_a), 0);
        step();
        flush = 1'b0;
        #1;
        check("flush.busy", W'(busy_a), 0);
        check("flush.ready", W'(ready_a), 1);
        seen = ov_a;
        for (int i = 0; i < 40; i++) begin
            step();
            seen = seen | ov_a;
        end
        check("flush.no_valid", W'(seen), 0);
        check_op("flush.next", 0, 0, 0, 9, 3, 11);

        // Hold in DONE, then back-to-back accept
        run_op(0, 0, 0, 100, 7, 3, res, otag, lat);
        check("hold.res0", res, 14);
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold.valid", W'(ov_a), 1);
            check("hold.res", res_a, 14);
        end
        src1 = 50; src2 = 5; tag = 12; valid_a = 1'b1; out_ready = 1'b1;
        #1;
        check("b2b.ready", W'(ready_a), 1);
        step();
        valid_a = 1'b0;
        out_ready = 1'b0;
        check("b2b.busy", W'(busy_a), 1);
        check("b2b.valid_low", W'(ov_a), 0);
        lat = 1;
        while (!ov_a && lat < 100) begin
            step();
            lat++;
        end
        check("b2b.res", res_a, 10);
        check("b2b.tag", W'(otag_a), 12);
        check("b2b.lat", W'(lat), W + 1);
        consume();

        // Reset abandons an operation
        src1 = 77; src2 = 3; valid_a = 1'b1;
        step();
        valid_a = 1'b0;
        repeat (4) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check("midrst.valid", W'(ov_a), 0);
        check("midrst.busy", W'(busy_a), 0);
        check("midrst.ready", W'(ready_a), 1);
        check("midrst.res", res_a, 0);

        // Two quotient bits per cycle
        check_op("bpc2.q", 1, 0, 0, 32'hFFFF_FFFF, 32'h10, 13);
        check_op("bpc2.r", 1, 0, 1, 32'hFFFF_FFFF, 32'h10, 14);
        check_op("bpc2.s", 1, 1, 1, 32'hFFFF_FF85, 32'h0000_000B, 15);

        // Randomized operations on both instances
        for (int n = 0; n < 30; n++) begin
            sel = 1'($urandom_range(0, 2) == 0);
            sgn = 1'($urandom_range(0, 1));
            md  = 1'($urandom_range(0, 1));
            t   = TW'($urandom);
            a   = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: b = W'($urandom_range(1, 15));
                2: b = '1;
                3: b = a >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
                sgn = 1'b1;
            end
            check_op("rand", sel, sgn, md, a, b, t);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
